qsfp_poll_cov_monitor: RTL
==========================

# qsfp_poll_cov_monitor

Parametrised, synthesizable coverage and protocol monitor for the QSFP controller poller FSMs. It samples the poller state, pause, poll-enable, page and soft-reset signals of NUM_CH controller instances. Per channel it accumulates a state-transition hit bitmap, a page-visit bitmap, event counters and sticky illegal-behaviour flags. Results are read through a registered readback port, so the same block serves unit benches, multi-port top-level benches and on-board debug CSRs.

## Interface
- NUM_CH, 4, number of monitored QSFP controller channels (1..16)
- STATE_W, 4, poller state width (3..5); transition bitmap is 2^(2*STATE_W) bits per channel
- PAGE_W, 8, curr_rd_page width
- NUM_PAGES, 4, pages tracked in the visit bitmap (1..30)
- CNT_W, 16, event counter width (1..16)

- clk  in  1  monitor clock, same domain as controller clk
- rst_n  in  1  synchronous, active-low reset
- sample_en  in  1  qualifies all sampling inputs this cycle
- poller_state  in  NUM_CH*STATE_W  channel c at [c*STATE_W +: STATE_W]
- poll_en  in  NUM_CH  per-channel poll enable
- fsm_paused  in  NUM_CH  per-channel poller paused
- curr_rd_page  in  NUM_CH*PAGE_W  per-channel current read page
- softreset  in  NUM_CH  per-channel config_softresetqsfpc
- clr  in  1  pulse; clears all accumulated coverage
- rd_en  in  1  readback request
- rd_ch  in  $clog2(NUM_CH) (min 1)  channel to read
- rd_sel  in  2  readback word class
- rd_idx  in  2*STATE_W-5  transition-bitmap word index
- rd_data  out  32  readback data
- rd_valid  out  1  rd_data valid
- illegal_any  out  1  OR of all per-channel illegal flags
- illegal_ch  out  NUM_CH  per-channel sticky illegal flag

## Operation
- Per channel: prev_state, prev_valid, prev_paused, trans_hit bitmap, page_hit[NUM_PAGES-1:0], page_oor flag, illegal flag, and CNT_W counters pause_cnt, sreset_cnt, trans_cnt.
- All updates occur only when sample_en=1, except clr and rst_n.
- Baseline sample (prev_valid=0): load prev_state, set prev_valid. No transition is recorded.
- Transition: prev_valid=1 and state!=prev_state. Set trans_hit[{prev_state,state}], increment trans_cnt, load prev_state. Equal states record nothing.
- Illegal cases (sticky until clr):
  - a transition while poll_en=0 in both the previous and current sample;
  - a transition while fsm_paused=1 in the previous sample and in the current sample.
- Pause event: fsm_paused rising edge versus prev_paused. Increments pause_cnt.
- Page: if curr_rd_page < NUM_PAGES, set page_hit[page]; otherwise set page_oor.
- softreset=1 while sampling:
  - increments sreset_cnt once per sampled cycle;
  - clears prev_valid, so the next sample is a baseline;
  - leaves the bitmaps and other counters intact;
  - suppresses transition and illegal detection that cycle.
- All counters saturate at 2^CNT_W-1 and never wrap.
- clr zeroes all bitmaps, counters, flags and prev_valid. clr has priority over a simultaneous sample, which is discarded.
- Readback for channel rd_ch:
  - rd_sel=0: {pause_cnt, sreset_cnt}, each zero-extended to 16 bits;
  - rd_sel=1: {page_oor, illegal, zeros, page_hit};
  - rd_sel=2: trans_cnt, zero-extended;
  - rd_sel=3: trans_hit[rd_idx*32 +: 32].
- Out-of-range rd_ch returns 0 with rd_valid=1.

## Timing
- Reset: every output, register, bitmap and counter is 0, and prev_valid=0.
- Sample-to-state latency is 1 cycle. An update sampled at edge N is visible to a read issued at edge N+1.
- A read issued in the same cycle as an update returns the pre-update value.
- rd_valid is asserted exactly 1 cycle after rd_en and lasts 1 cycle. Back-to-back reads give back-to-back rd_valid. rd_data holds its last value when rd_valid=0.
- illegal_ch and illegal_any are registered and assert the cycle after the offending sample.
- rst_n low mid-operation clears everything on that edge. The first sample after release is a baseline.
- The controller has no backpressure. Every sampled cycle is consumed.

## Test plan
- Reset then state sequence 0→1→2→2→1 on channel 0 → trans_hit bits {0,1},{1,2},{2,1} set, trans_cnt=3, other channels all zero.
- Transition 3→4 while fsm_paused=1 in both samples on channel 2 → illegal_ch=4'b0100 next cycle, illegal_any=1. Flags stay set until clr, then read 0.
- Pages 0,1,3,7 on channel 1 with NUM_PAGES=4 → rd_sel=1 reads 0x8000000B.
- softreset pulse between state 5 and state 6 → no {5,6} bit set, sreset_cnt=1. A following 6→7 records {6,7}.
- CNT_W=4 with 20 fsm_paused rising edges → pause_cnt=15, reads 0x000F0000.
- clr coincident with a transition, plus rd_en in the same cycle → read returns pre-clr data, the transition is not recorded, and all subsequent reads are 0.

Source files
------------

// File: rtl/qsfp_poll_cov_monitor_if.sv
// qsfp_poll_cov_monitor_if
//
// Purpose: readback bus of the QSFP poller coverage monitor. A requester
// issues rd_en with a channel / word-class / word-index selection and the
// monitor answers one cycle later with rd_valid and rd_data.
//
// Signals:
//   rd_en     requester -> monitor   readback request (one word per cycle)
//   rd_ch     requester -> monitor   channel to read
//   rd_sel    requester -> monitor   word class (counters, pages/flags, trans count, trans bitmap)
//   rd_idx    requester -> monitor   32-bit word index into the transition bitmap
//   rd_data   monitor -> requester   readback word, holds its value between reads
//   rd_valid  monitor -> requester   rd_data carries the answer to the previous cycle's rd_en
//
// Modports: master = requester side, slave = monitor side.

interface qsfp_poll_cov_monitor_if #(
    parameter int NUM_CH  = 4,
    parameter int STATE_W = 4
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = 2 * STATE_W - 5;

    logic             rd_en;
    logic [CH_W-1:0]  rd_ch;
    logic [1:0]       rd_sel;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;
    logic             rd_valid;

    modport master (
        output rd_en, rd_ch, rd_sel, rd_idx,
        input  rd_data, rd_valid
    );

    modport slave (
        input  rd_en, rd_ch, rd_sel, rd_idx,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/qsfp_poll_cov_monitor.sv
// qsfp_poll_cov_monitor
//
// Purpose: coverage and protocol monitor for NUM_CH QSFP controller poller
// FSMs. On every qualified sample it records, per channel, which state
// transitions occurred (2^(2*STATE_W)-bit hit bitmap), which read pages were
// visited, saturating pause / soft-reset / transition counters and sticky
// illegal-behaviour flags. Results are read through a registered readback bus.
//
// Ports:
//   clk           monitor clock (controller clock domain)
//   rst_n         synchronous active-low reset
//   sample_en     qualifies all sampling inputs this cycle
//   poller_state  per-channel poller state, channel c at [c*STATE_W +: STATE_W]
//   poll_en       per-channel poll enable
//   fsm_paused    per-channel poller paused
//   curr_rd_page  per-channel current read page, channel c at [c*PAGE_W +: PAGE_W]
//   softreset     per-channel controller soft reset
//   clr           clears all accumulated coverage (wins over a same-cycle sample)
//   rd            readback bus (slave side)
//   illegal_any   OR of all per-channel illegal flags
//   illegal_ch    per-channel sticky illegal flags

module qsfp_poll_cov_monitor #(
    parameter int NUM_CH    = 4,
    parameter int STATE_W   = 4,
    parameter int PAGE_W    = 8,
    parameter int NUM_PAGES = 4,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_en,
    input  logic [NUM_CH*STATE_W-1:0]   poller_state,
    input  logic [NUM_CH-1:0]           poll_en,
    input  logic [NUM_CH-1:0]           fsm_paused,
    input  logic [NUM_CH*PAGE_W-1:0]    curr_rd_page,
    input  logic [NUM_CH-1:0]           softreset,
    input  logic                        clr,
    qsfp_poll_cov_monitor_if.slave      rd,
    output logic                        illegal_any,
    output logic [NUM_CH-1:0]           illegal_ch
);
    localparam int TRANS_W = 2 ** (2 * STATE_W);
    localparam logic [NUM_PAGES-1:0] PAGE_ONE = NUM_PAGES'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    logic [STATE_W-1:0]   prev_state  [NUM_CH];
    logic [NUM_CH-1:0]    prev_valid;
    logic [NUM_CH-1:0]    prev_paused;
    logic [NUM_CH-1:0]    prev_poll_en;
    logic [TRANS_W-1:0]   trans_hit   [NUM_CH];
    logic [NUM_PAGES-1:0] page_hit    [NUM_CH];
    logic [NUM_CH-1:0]    page_oor;
    logic [CNT_W-1:0]     pause_cnt   [NUM_CH];
    logic [CNT_W-1:0]     sreset_cnt  [NUM_CH];
    logic [CNT_W-1:0]     trans_cnt   [NUM_CH];

    logic [STATE_W-1:0]   cur_state   [NUM_CH];
    logic [PAGE_W-1:0]    cur_page    [NUM_CH];
    logic [2*STATE_W-1:0] trans_idx   [NUM_CH];
    logic [NUM_CH-1:0]    is_trans;
    logic [NUM_CH-1:0]    is_illegal;
    logic [NUM_CH-1:0]    pause_rise;
    logic [NUM_CH-1:0]    page_in;
    logic [31:0]          rd_word;

    // Per-channel event decode. A soft reset in the sampled cycle masks
    // transition (and therefore illegal) detection; the illegal rules look at
    // the previous sample's poll_en / fsm_paused and the current one.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cur_state[c]  = poller_state[c*STATE_W +: STATE_W];
            cur_page[c]   = curr_rd_page[c*PAGE_W +: PAGE_W];
            trans_idx[c]  = {prev_state[c], cur_state[c]};
            is_trans[c]   = prev_valid[c] && !softreset[c] && (cur_state[c] != prev_state[c]);
            is_illegal[c] = is_trans[c] &&
                            ((!prev_poll_en[c] && !poll_en[c]) ||
                             (prev_paused[c] && fsm_paused[c]));
            pause_rise[c] = fsm_paused[c] && !prev_paused[c];
            page_in[c]    = 32'(cur_page[c]) < NUM_PAGES;
        end
    end

    // Coverage state. clr discards a coincident sample entirely; it wipes the
    // accumulated results and prev_valid but keeps the previous-sample
    // pause/poll_en history so edge detection stays continuous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_valid   <= '0;
            prev_paused  <= '0;
            prev_poll_en <= '0;
            page_oor     <= '0;
            illegal_ch   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                prev_state[c] <= '0;
                trans_hit[c]  <= '0;
                page_hit[c]   <= '0;
                pause_cnt[c]  <= '0;
                sreset_cnt[c] <= '0;
                trans_cnt[c]  <= '0;
            end
        end else if (clr) begin
            prev_valid <= '0;
            page_oor   <= '0;
            illegal_ch <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                trans_hit[c]  <= '0;
                page_hit[c]   <= '0;
                pause_cnt[c]  <= '0;
                sreset_cnt[c] <= '0;
                trans_cnt[c]  <= '0;
            end
        end else if (sample_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                prev_paused[c]  <= fsm_paused[c];
                prev_poll_en[c] <= poll_en[c];

                if (pause_rise[c] && (pause_cnt[c] != CNT_MAX)) begin
                    pause_cnt[c] <= pause_cnt[c] + CNT_ONE;
                end

                if (page_in[c]) begin
                    page_hit[c] <= page_hit[c] | (PAGE_ONE << cur_page[c]);
                end else begin
                    page_oor[c] <= 1'b1;
                end

                // Soft reset forces the next sample to be a fresh baseline.
                if (softreset[c]) begin
                    prev_valid[c] <= 1'b0;
                    if (sreset_cnt[c] != CNT_MAX) begin
                        sreset_cnt[c] <= sreset_cnt[c] + CNT_ONE;
                    end
                end else if (!prev_valid[c]) begin
                    prev_state[c] <= cur_state[c];
                    prev_valid[c] <= 1'b1;
                end else if (is_trans[c]) begin
                    prev_state[c]               <= cur_state[c];
                    trans_hit[c][trans_idx[c]] <= 1'b1;
                    if (trans_cnt[c] != CNT_MAX) begin
                        trans_cnt[c] <= trans_cnt[c] + CNT_ONE;
                    end
                    if (is_illegal[c]) begin
                        illegal_ch[c] <= 1'b1;
                    end
                end
            end
        end
    end

    // illegal_any is a pure OR of flop outputs, so it moves on the same edge
    // as illegal_ch.
    assign illegal_any = |illegal_ch;

    // Readback word select from current (pre-update) register values.
    always_comb begin
        rd_word = '0;
        if (32'(rd.rd_ch) < NUM_CH) begin
            case (rd.rd_sel)
                2'd0: rd_word = {16'(pause_cnt[rd.rd_ch]), 16'(sreset_cnt[rd.rd_ch])};
                2'd1: begin
                    rd_word     = 32'(page_hit[rd.rd_ch]);
                    rd_word[31] = page_oor[rd.rd_ch];
                    rd_word[30] = illegal_ch[rd.rd_ch];
                end
                2'd2: rd_word = 32'(trans_cnt[rd.rd_ch]);
                default: rd_word = trans_hit[rd.rd_ch][{rd.rd_idx, 5'b00000} +: 32];
            endcase
        end
    end

    // Registered readback: one rd_valid per rd_en, data held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
        end else begin
            rd.rd_valid <= rd.rd_en;
            if (rd.rd_en) begin
                rd.rd_data <= rd_word;
            end
        end
    end
endmodule
